// File: rtl/mux2_sel_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux select.
// Grants hand off cleanly between owners and an optional hold limit prevents starvation.
module mux2_sel_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done,
    output logic sel,
    output logic grant_a,
    output logic grant_b,
    output logic busy,
    output logic timeout
);

    localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_b, last_b_n;
    logic          sel_n, timeout_n;
    logic          own_req, oth_req, hit, by_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last_b  <= 1'b1;
            sel     <= 1'b0;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            last_b  <= last_b_n;
            sel     <= sel_n;
            grant_a <= (state_n == GNT_A);
            grant_b <= (state_n == GNT_B);
            busy    <= (state_n != IDLE);
            timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_b_n  = last_b;
        timeout_n = 1'b0;
        own_req   = (state == GNT_B) ? req_b : req_a;
        oth_req   = (state == GNT_B) ? req_a : req_b;
        hit       = (MAX_HOLD > 0) && (cnt == CW'(LIM));
        by_to     = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                // On a tie, the requester that did not own last wins.
                if (req_a && (!req_b || last_b)) begin
                    state_n  = GNT_A;
                    last_b_n = 1'b0;
                end else if (req_b) begin
                    state_n  = GNT_B;
                    last_b_n = 1'b1;
                end
            end
            GNT_A, GNT_B: begin
                if (!own_req || done || hit) begin
                    // Only a pure limit expiry counts as a timeout.
                    by_to     = hit && own_req && !done;
                    timeout_n = by_to;
                    cnt_n     = '0;
                    if (oth_req) begin
                        state_n  = (state == GNT_A) ? GNT_B : GNT_A;
                        last_b_n = (state == GNT_A);
                    end else if (by_to) begin
                        last_b_n = (state == GNT_B);
                    end else begin
                        state_n = IDLE;
                    end
                end else if (cnt != CW'(LIM)) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        case (state_n)
            GNT_A:   sel_n = 1'b0;
            GNT_B:   sel_n = 1'b1;
            default: sel_n = sel;
        endcase
    end

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Bench for mux2_sel_arbiter: two instances (hold limit 4 and disabled) share
// directed and random stimulus and are compared every cycle with an ownership model.
module tb_mux2_sel_arbiter;

    logic clk = 1'b0;
    logic rst, req_a, req_b, done;
    logic sel4, ga4, gb4, busy4, to4;
    logic sel0, ga0, gb0, busy0, to0;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: owner 0=none 1=A 2=B, cycles held, last owner, timeout flag, select.
    int   mh[2] = '{4, 0};
    int   m_own[2];
    int   m_held[2];
    int   m_last[2];
    logic m_to[2];
    logic m_sel[2];

    always #5 clk = ~clk;

    mux2_sel_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
        .sel(sel4), .grant_a(ga4), .grant_b(gb4), .busy(busy4), .timeout(to4)
    );

    mux2_sel_arbiter #(.MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
        .sel(sel0), .grant_a(ga0), .grant_b(gb0), .busy(busy0), .timeout(to0)
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i]  = 0;
            m_held[i] = 0;
            m_last[i] = 2;
            m_to[i]   = 1'b0;
            m_sel[i]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        logic rq[3];
        rq[0] = 1'b0;
        rq[1] = req_a;
        rq[2] = req_b;
        for (int i = 0; i < 2; i++) begin
            int   o;
            int   y;
            logic at_limit;
            logic by_limit;
            o = m_own[i];
            if (o == 0) begin
                m_to[i] = 1'b0;
                if (req_a && req_b) o = (m_last[i] == 1) ? 2 : 1;
                else if (req_a)     o = 1;
                else if (req_b)     o = 2;
                if (o != 0) begin
                    m_held[i] = 0;
                    m_last[i] = o;
                end
            end else begin
                y        = 3 - o;
                at_limit = (mh[i] > 0) && (m_held[i] == mh[i] - 1);
                if (!rq[o] || done || at_limit) begin
                    by_limit  = at_limit && rq[o] && !done;
                    m_to[i]   = by_limit;
                    m_held[i] = 0;
                    if (rq[y]) begin
                        o         = y;
                        m_last[i] = y;
                    end else if (by_limit) begin
                        m_last[i] = o;
                    end else begin
                        o = 0;
                    end
                end else begin
                    m_held[i] = m_held[i] + 1;
                    m_to[i]   = 1'b0;
                end
            end
            m_own[i] = o;
            if (o == 1) m_sel[i] = 1'b0;
            if (o == 2) m_sel[i] = 1'b1;
        end
    endfunction

    task automatic check(input string tag);
        logic [4:0] obs[2];
        logic [4:0] want;
        obs[0] = {sel4, ga4, gb4, busy4, to4};
        obs[1] = {sel0, ga0, gb0, busy0, to0};
        for (int i = 0; i < 2; i++) begin
            want = {m_sel[i], m_own[i] == 1, m_own[i] == 2, m_own[i] != 0, m_to[i]};
            n_assert++;
            assert (obs[i] === want) else begin
                n_fail++;
                $error("FAIL %s max_hold=%0d {sel,ga,gb,busy,to} observed=%b expected=%b",
                       tag, mh[i], obs[i], want);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check(tag);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        done  = 1'b0;
        model_reset();
        #2 check("reset");
        #10 rst = 1'b0;

        req_a = 1'b1;
        repeat (3) step("a_only");
        req_a = 1'b0;
        repeat (2) step("a_drop");

        req_a = 1'b1; req_b = 1'b1;
        repeat (20) step("both_rr");
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) step("idle");

        req_a = 1'b1;
        repeat (2) step("a_grant");
        req_b = 1'b1; done = 1'b1;
        step("done_handoff");
        done = 1'b0; req_a = 1'b0;
        step("b_after_done");
        req_b = 1'b0;
        repeat (2) step("idle2");

        req_a = 1'b1; done = 1'b1;
        repeat (4) step("done_first_cycle");
        req_a = 1'b0; done = 1'b0;
        repeat (2) step("idle3");

        req_b = 1'b1;
        repeat (10) step("b_only_hold");
        req_b = 1'b0;
        repeat (2) step("b_drop");

        req_a = 1'b1; req_b = 1'b1;
        repeat (100) step("long_both");
        req_a = 1'b0;
        repeat (3) step("a_release");
        req_b = 1'b0;
        repeat (2) step("idle4");

        req_b = 1'b1;
        repeat (2) step("b_before_rst");
        async_reset("async_rst");
        req_a = 1'b1;
        repeat (3) step("after_rst");
        req_a = 1'b0; req_b = 1'b0;
        step("idle5");

        for (int k = 0; k < 500; k++) begin
            req_a = ($urandom_range(0, 3) != 0);
            req_b = ($urandom_range(0, 3) != 0);
            done  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_sel_arbiter.md
Name: mux2_sel_arbiter

Overview:
- Round-robin arbiter for two requesters (A, B).
- Generates the registered select line for the downstream 2:1 mux, plus one-hot grants.
- Guarantees the mux select changes only on a clean ownership handoff.
- Enforces an optional maximum hold time so neither source can starve the other.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant; 0 disables the timeout.
CW, $clog2(MAX_HOLD+1) (minimum 1), hold-counter width; derived, not user-set.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_a  input  1  requester A wants the mux output.
req_b  input  1  requester B wants the mux output.
done  input  1  current owner releases the grant this cycle; ignored in IDLE.
sel  output  1  mux select, registered; 0 routes A, 1 routes B.
grant_a  output  1  A owns the mux; registered.
grant_b  output  1  B owns the mux; registered.
busy  output  1  grant_a | grant_b, registered.
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async assert, sync release): state IDLE, sel=0, grant_a=grant_b=busy=timeout=0, hold counter=0, last_owner=B (A wins the first tie).
- States:
  - IDLE: no grant.
  - GNT_A: grant_a=1, sel=0.
  - GNT_B: grant_b=1, sel=1.
- All outputs are registered. Latency from a request sampled in IDLE to its grant = 1 cycle.
- IDLE transitions:
  - req_a only -> GNT_A.
  - req_b only -> GNT_B.
  - both -> grant the requester that is not last_owner.
  - neither -> stay; sel holds its last value.
- GNT_X release condition, evaluated each cycle: req_X=0, OR done=1, OR (MAX_HOLD>0 AND counter==MAX_HOLD-1).
- On release:
  - If the other requester is asserting -> go directly to GNT_other (no idle gap). grant_X falls and grant_other rises on the same edge; sel flips on that edge.
  - Else, if release was by timeout only and req_X is still 1 -> re-grant X; counter restarts at 0.
  - Else -> IDLE.
- Counter:
  - Counts cycles in the current grant: 0 on the grant's first cycle, +1 per held cycle.
  - Cleared on every new grant or re-grant.
  - Never wraps: it saturates at MAX_HOLD-1, where release occurs.
- timeout: high for exactly the cycle after a timeout-triggered release, including a timeout re-grant. It is not asserted when done or req drop coincide with the limit; done/req take precedence in classification.
- last_owner updates whenever a grant is issued.
- Invariants, every cycle: grant_a & grant_b == 0; sel == grant_b when busy; busy == grant_a | grant_b.
- done in the same cycle as the grant's first cycle releases immediately, giving a 1-cycle grant.
- Reset mid-grant: all outputs drop asynchronously; last_owner returns to B.

Test Plan:
- Reset then req_a=1 only for 3 cycles, then req_a=0 -> grant_a=1 from cycle 1 through 3 (after req_a falls it drops in 1 cycle), sel=0 throughout, busy mirrors grant_a.
- From IDLE, req_a=req_b=1 held, MAX_HOLD=4 -> GNT_A for 4 cycles, timeout pulse, GNT_B for 4 cycles, timeout, back to A; sel toggles 0,1,0 and grants never overlap.
- GNT_A active, req_b=1, done=1 on the 2nd cycle -> next edge grant_a=0, grant_b=1, sel=1, timeout=0.
- req_b only, MAX_HOLD=4, held 10 cycles -> grant_b stays 1 continuously, timeout pulses after cycles 4 and 8, sel=1 throughout.
- MAX_HOLD=0, req_a held 100 cycles with req_b=1 -> grant_a held all 100 cycles, timeout never asserts; req_a drop -> grant_b next cycle.
- Assert rst mid-GNT_B -> grant_b, busy, sel go to 0 immediately without a clock edge; after release with both requesting, A is granted first.
